// File: rtl/branch_flag_gen.sv
// branch_flag_gen: multi-cycle rs1 - rs2 compare that produces z/n/v/c flags
// for the branch unit. The subtraction is done as rs1 + ~rs2 + 1, CHUNK bits
// per cycle, least-significant chunk first; func3 travels with the operands.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid is
// high only in DONE and the flags/func3_out stay stable until out_ready.
module branch_flag_gen #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      func3_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            z,
    output logic            n,
    output logic            v,
    output logic            c,
    output logic [2:0]      func3_out,
    output logic [1:0]      state_dbg
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic            zacc;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   sum;
    logic             chunk_zero;
    logic             a_msb;
    logic             b_msb;

    assign state_dbg = state;

    // Select the operand chunk addressed by the chunk counter.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // One chunk of a + ~b + carry; the extra top bit is the carry into the next chunk.
    always_comb begin
        sum        = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, carry};
        chunk_zero = (sum[CHUNK-1:0] == '0);
        a_msb      = a_q[XLEN-1];
        b_msb      = b_q[XLEN-1];
    end

    // Control FSM with the chunk datapath and registered flags/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            z         <= 1'b0;
            n         <= 1'b0;
            v         <= 1'b0;
            c         <= 1'b0;
            func3_out <= 3'b000;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            zacc      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q       <= rs1;
                        b_q       <= rs2;
                        func3_out <= func3_in;
                        carry     <= 1'b1;
                        zacc      <= 1'b1;
                        cnt       <= '0;
                        in_ready  <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    carry <= sum[CHUNK];
                    zacc  <= zacc & chunk_zero;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Final chunk: its top bit is the sign of the full difference.
                        z         <= zacc & chunk_zero;
                        n         <= sum[CHUNK-1];
                        c         <= sum[CHUNK];
                        v         <= (a_msb != b_msb) && (sum[CHUNK-1] != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_flag_gen.sv
// Bench for branch_flag_gen: one CHUNK=8 instance and one CHUNK=32 instance
// sharing operand/reset/out_ready wires. Expected {func3,z,n,v,c} values are
// hand-computed and queued by the driver; per-instance monitors compare.
module tb_branch_flag_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  func3_in;
    logic        out_ready;

    logic        iv8, rdy8, ov8, z8, n8, v8, c8;
    logic [2:0]  f3o8;
    logic [1:0]  st8;
    logic        iv32, rdy32, ov32, z32, n32, v32, c32;
    logic [2:0]  f3o32;
    logic [1:0]  st32;

    logic [6:0]  exp_q8[$];
    logic [6:0]  exp_q32[$];
    int          acc_q8[$];
    int          acc_q32[$];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    logic pv8  = 1'b0;
    logic pv32 = 1'b0;

    branch_flag_gen #(.XLEN(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8),
        .rs1(rs1), .rs2(rs2), .func3_in(func3_in),
        .out_valid(ov8), .out_ready(out_ready),
        .z(z8), .n(n8), .v(v8), .c(c8), .func3_out(f3o8), .state_dbg(st8)
    );

    branch_flag_gen #(.XLEN(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32),
        .rs1(rs1), .rs2(rs2), .func3_in(func3_in),
        .out_valid(ov32), .out_ready(out_ready),
        .z(z32), .n(n32), .v(v32), .c(c32), .func3_out(f3o32), .state_dbg(st32)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Driver: present operands, wait for in_ready, queue the expected response.
    task automatic issue(input bit sel32, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [6:0] exp);
        bit ok = 1'b0;
        rs1 = a;
        rs2 = b;
        func3_in = f;
        if (sel32) iv32 = 1'b1; else iv8 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((sel32 ? rdy32 : rdy8) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("issue_timeout", 32'd0, 32'd1);
        else if (sel32) begin exp_q32.push_back(exp); acc_q32.push_back(cyc + 1); end
        else begin exp_q8.push_back(exp); acc_q8.push_back(cyc + 1); end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        iv32 = 1'b0;
    endtask

    task automatic drain(input bit sel32);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((sel32 ? exp_q32.size() : exp_q8.size()) == 0) break;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor for the CHUNK=8 instance
    always @(negedge clk) begin
        if (!rst && ov8) begin
            if (exp_q8.size() == 0) check("spurious_out8", 32'd1, 32'd0);
            else begin
                check("flags8", {25'd0, f3o8, z8, n8, v8, c8}, {25'd0, exp_q8[0]});
                check("in_ready_low8", {31'd0, rdy8}, 32'd0);
                if (!pv8 && acc_q8.size() > 0) check("latency8", cyc - acc_q8.pop_front(), 32'd4);
                if (out_ready) void'(exp_q8.pop_front());
            end
        end
        pv8 = ov8;
    end

    // Monitor for the CHUNK=32 instance
    always @(negedge clk) begin
        if (!rst && ov32) begin
            if (exp_q32.size() == 0) check("spurious_out32", 32'd1, 32'd0);
            else begin
                check("flags32", {25'd0, f3o32, z32, n32, v32, c32}, {25'd0, exp_q32[0]});
                check("in_ready_low32", {31'd0, rdy32}, 32'd0);
                if (!pv32 && acc_q32.size() > 0) check("latency32", cyc - acc_q32.pop_front(), 32'd1);
                if (out_ready) void'(exp_q32.pop_front());
            end
        end
        pv32 = ov32;
    end

    // Directed sequence; expected = {func3, z, n, v, c}
    initial begin
        rst = 1'b1;
        rs1 = '0;
        rs2 = '0;
        func3_in = '0;
        iv8 = 1'b0;
        iv32 = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state8", {25'd0, ov8, rdy8, z8, n8, v8, c8, f3o8 == 3'd0}, 32'b0100001);
        check("reset_state32", {25'd0, ov32, rdy32, z32, n32, v32, c32, f3o32 == 3'd0}, 32'b0100001);
        check("reset_fsm8", {30'd0, st8}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CHUNK=8 basic vectors
        issue(1'b0, 32'd5,         32'd5,         3'b000, {3'b000, 4'b1001});
        issue(1'b0, 32'd3,         32'd7,         3'b100, {3'b100, 4'b0100});
        issue(1'b0, 32'h8000_0000, 32'd1,         3'b101, {3'b101, 4'b0011});
        issue(1'b0, 32'h0000_0100, 32'd0,         3'b111, {3'b111, 4'b0001});
        issue(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b100, {3'b100, 4'b0110});
        drain(1'b0);

        // Backpressure in DONE with in_valid pulsed
        out_ready = 1'b0;
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 3'b110, {3'b110, 4'b0101});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov8) break;
        end
        check("bp_valid8", {31'd0, ov8}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            iv8 = 1'b1;
            rs1 = 32'h0000_0000;
            rs2 = 32'h1234_5678;
            func3_in = 3'b001;
            @(negedge clk);
            check("bp_in_ready8", {31'd0, rdy8}, 32'd0);
        end
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release8", {29'd0, ov8, rdy8, st8 == 2'd0}, 32'b011);
        check("bp_flags_held8", {25'd0, f3o8, z8, n8, v8, c8}, {25'd0, 3'b110, 4'b0101});
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_capture8", {30'd0, ov8, rdy8}, 32'b01);

        // Reset in the middle of BUSY aborts the op
        issue(1'b0, 32'h0000_0011, 32'h0000_0022, 3'b010, {3'b010, 4'b0100});
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_abort8", {29'd0, ov8, rdy8, st8 == 2'd0}, 32'b011);
        exp_q8.delete();
        acc_q8.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b0, 32'd1, 32'd2, 3'b001, {3'b001, 4'b0101 ^ 4'b0001});
        drain(1'b0);

        // CHUNK=32 single-cycle compare
        issue(1'b1, 32'd5,         32'd5, 3'b000, {3'b000, 4'b1001});
        issue(1'b1, 32'd3,         32'd7, 3'b100, {3'b100, 4'b0100});
        issue(1'b1, 32'h8000_0000, 32'd1, 3'b101, {3'b101, 4'b0011});
        issue(1'b1, 32'h0000_0100, 32'd0, 3'b111, {3'b111, 4'b0001});
        drain(1'b1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty8", exp_q8.size(), 32'd0);
        check("queue_empty32", exp_q32.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
